// File: rtl/noc_global_pkg.sv
// Shared NoC definitions: arbiter form selector, index-width helper and clock-gating policy.
package noc_global;

    typedef enum logic [1:0] {
        ARB_TYPES_NONE = 2'd0,
        ARB_TYPES_FPA  = 2'd1,
        ARB_TYPES_RR   = 2'd2
    } ArbForm;

    // 1: state flops load only on an accepted beat or reset
    localparam bit CLOCK_GATING_FIRENDLY = 1'b1;

    // ceil(log2(n)), but never narrower than one bit
    function automatic int log2c_1if1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/noc_prio_search.sv
// Rotating first-one search: scans req upward from start, wrapping N-1 -> 0.
module noc_prio_search
    import noc_global::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = log2c_1if1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    function automatic logic [IDX_W-1:0] wrap_pos(input logic [IDX_W-1:0] s, input int k);
        int base;
        int pos;
        base = (int'(s) >= N) ? 0 : int'(s);
        pos  = base + k;
        pos  = (pos >= N) ? (pos - N) : pos;
        return IDX_W'(pos);
    endfunction

    // first set bit at or after start wins; later hits are masked by found
    always_comb begin
        onehot = {N{1'b0}};
        idx    = {IDX_W{1'b0}};
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            logic [IDX_W-1:0] p;
            logic             hit;
            p   = wrap_pos(start, k);
            hit = !found && req[p];
            onehot[p] = onehot[p] | hit;
            idx   = hit ? p : idx;
            found = found | hit;
        end
    end

endmodule

// File: rtl/noc_arbiter_lockable.sv
// Lockable N-input arbiter (fixed-priority, round-robin or pass-through). Grant is combinational
// from req; pointer and lock state advance only on an accepted beat.
module noc_arbiter_lockable
    import noc_global::*;
#(
    parameter int     N_REQ    = 4,
    parameter ArbForm ARB_TYPE = ARB_TYPES_RR,
    parameter int     IDX_W    = log2c_1if1(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             update,
    input  logic             lock,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             locked
);

    if (N_REQ < 1) begin : g_bad_n
        $fatal(1, "noc_arbiter_lockable: N_REQ must be >= 1");
    end
    if ((ARB_TYPE == ARB_TYPES_NONE) && (N_REQ != 1)) begin : g_bad_none
        $fatal(1, "noc_arbiter_lockable: ARB_TYPES_NONE requires N_REQ == 1");
    end

    logic [N_REQ-1:0] free_gnt_s;
    logic [IDX_W-1:0] free_idx_s;
    logic             free_found_s;
    logic [IDX_W-1:0] prio_ptr_s;
    logic             accepted_s;
    logic             load_en_s;
    logic             lock_r;
    logic [IDX_W-1:0] lock_idx_r;
    logic             lock_nxt_s;
    logic [IDX_W-1:0] lock_idx_nxt_s;

    assign accepted_s = update & gnt_valid;
    assign load_en_s  = accepted_s | ~CLOCK_GATING_FIRENDLY;

    if (ARB_TYPE == ARB_TYPES_NONE) begin : g_none
        assign free_gnt_s   = req;
        assign free_idx_s   = {IDX_W{1'b0}};
        assign free_found_s = req[0];
        assign prio_ptr_s   = {IDX_W{1'b0}};
    end else begin : g_search
        if (ARB_TYPE == ARB_TYPES_RR) begin : g_rr_ptr
            logic [IDX_W-1:0] prio_ptr_r;
            logic [IDX_W-1:0] prio_ptr_nxt_s;

            // single-beat or last beat moves priority just past the winner
            always_comb begin
                if (accepted_s && !lock) begin
                    if (gnt_idx == IDX_W'(N_REQ - 1)) begin
                        prio_ptr_nxt_s = {IDX_W{1'b0}};
                    end else begin
                        prio_ptr_nxt_s = gnt_idx + IDX_W'(1'b1);
                    end
                end else begin
                    prio_ptr_nxt_s = prio_ptr_r;
                end
            end

            // round-robin pointer register
            always_ff @(posedge clk) begin
                if (rst) begin
                    prio_ptr_r <= {IDX_W{1'b0}};
                end else if (load_en_s) begin
                    prio_ptr_r <= prio_ptr_nxt_s;
                end else begin
                    prio_ptr_r <= prio_ptr_r;
                end
            end

            assign prio_ptr_s = prio_ptr_r;
        end else begin : g_fpa_ptr
            assign prio_ptr_s = {IDX_W{1'b0}};
        end

        noc_prio_search #(
            .N     (N_REQ),
            .IDX_W (IDX_W)
        ) u_search (
            .req    (req),
            .start  (prio_ptr_s),
            .onehot (free_gnt_s),
            .idx    (free_idx_s),
            .found  (free_found_s)
        );
    end

    // lock is taken on a non-last accepted beat, dropped on the last one
    always_comb begin
        if (accepted_s) begin
            lock_nxt_s     = lock;
            lock_idx_nxt_s = lock ? gnt_idx : lock_idx_r;
        end else begin
            lock_nxt_s     = lock_r;
            lock_idx_nxt_s = lock_idx_r;
        end
    end

    // lock state register
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_r     <= 1'b0;
            lock_idx_r <= {IDX_W{1'b0}};
        end else if (load_en_s) begin
            lock_r     <= lock_nxt_s;
            lock_idx_r <= lock_idx_nxt_s;
        end else begin
            lock_r     <= lock_r;
            lock_idx_r <= lock_idx_r;
        end
    end

    // while locked only the owner can be granted; a dropped req stalls without releasing
    always_comb begin
        gnt       = {N_REQ{1'b0}};
        gnt_idx   = {IDX_W{1'b0}};
        gnt_valid = 1'b0;
        if (lock_r) begin
            gnt_valid           = req[lock_idx_r];
            gnt[lock_idx_r]     = req[lock_idx_r];
            gnt_idx             = req[lock_idx_r] ? lock_idx_r : {IDX_W{1'b0}};
        end else begin
            gnt       = free_gnt_s;
            gnt_idx   = free_idx_s;
            gnt_valid = free_found_s;
        end
    end

    assign locked = lock_r;

endmodule

// File: tb/tb_noc_arbiter_lockable.sv
// Bench for noc_arbiter_lockable: four configurations (RR/4, FPA/4, RR/3, NONE/1) share stimulus
// and are compared against a behavioural model plus directed scenarios.
module tb_noc_arbiter_lockable;
    import noc_global::*;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       update;
    logic       lock;

    logic [3:0] gnt0;  logic [1:0] idx0;  logic val0;  logic lkd0;
    logic [3:0] gnt1;  logic [1:0] idx1;  logic val1;  logic lkd1;
    logic [2:0] gnt2;  logic [1:0] idx2;  logic val2;  logic lkd2;
    logic [0:0] gnt3;  logic [0:0] idx3;  logic val3;  logic lkd3;

    int checks = 0;
    int errors = 0;

    // model: form 0=NONE 1=FPA 2=RR
    int m_n[4]    = '{4, 4, 3, 1};
    int m_form[4] = '{2, 1, 2, 0};
    int m_ptr[4];
    int m_lidx[4];
    bit m_lock[4];

    noc_arbiter_lockable #(.N_REQ(4), .ARB_TYPE(ARB_TYPES_RR)) u_rr4 (
        .clk(clk), .rst(rst), .req(req), .update(update), .lock(lock),
        .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(val0), .locked(lkd0));
    noc_arbiter_lockable #(.N_REQ(4), .ARB_TYPE(ARB_TYPES_FPA)) u_fpa4 (
        .clk(clk), .rst(rst), .req(req), .update(update), .lock(lock),
        .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(val1), .locked(lkd1));
    noc_arbiter_lockable #(.N_REQ(3), .ARB_TYPE(ARB_TYPES_RR)) u_rr3 (
        .clk(clk), .rst(rst), .req(req[2:0]), .update(update), .lock(lock),
        .gnt(gnt2), .gnt_idx(idx2), .gnt_valid(val2), .locked(lkd2));
    noc_arbiter_lockable #(.N_REQ(1), .ARB_TYPE(ARB_TYPES_NONE)) u_none1 (
        .clk(clk), .rst(rst), .req(req[0:0]), .update(update), .lock(lock),
        .gnt(gnt3), .gnt_idx(idx3), .gnt_valid(val3), .locked(lkd3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit bit_at(input logic [3:0] v, input int p);
        return v[p[1:0]] === 1'b1;
    endfunction

    // winner under the arbitration rules, -1 when nobody is granted
    function automatic int exp_winner(input int inst, input logic [3:0] r);
        int n;
        int start;
        int p;
        n = m_n[inst];
        if (m_lock[inst]) return bit_at(r, m_lidx[inst]) ? m_lidx[inst] : -1;
        if (m_form[inst] == 0) return bit_at(r, 0) ? 0 : -1;
        start = (m_form[inst] == 2) ? m_ptr[inst] : 0;
        for (int k = 0; k < n; k++) begin
            p = (start + k) % n;
            if (bit_at(r, p)) return p;
        end
        return -1;
    endfunction

    task automatic get_out(input int inst, output logic [3:0] g, output logic [3:0] idx,
                           output logic v, output logic l);
        case (inst)
            0:       begin g = gnt0;           idx = {2'b00, idx0}; v = val0; l = lkd0; end
            1:       begin g = gnt1;           idx = {2'b00, idx1}; v = val1; l = lkd1; end
            2:       begin g = {1'b0, gnt2};   idx = {2'b00, idx2}; v = val2; l = lkd2; end
            default: begin g = {3'b000, gnt3}; idx = {3'b000, idx3}; v = val3; l = lkd3; end
        endcase
    endtask

    // one clock: model state advances from the inputs held across the edge
    task automatic step();
        int w[4];
        for (int i = 0; i < 4; i++) w[i] = exp_winner(i, req);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                m_ptr[i] = 0; m_lock[i] = 1'b0; m_lidx[i] = 0;
            end else if (update && w[i] >= 0) begin
                if (lock) begin
                    m_lock[i] = 1'b1; m_lidx[i] = w[i];
                end else begin
                    m_lock[i] = 1'b0;
                    if (m_form[i] == 2) m_ptr[i] = (w[i] + 1) % m_n[i];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; update = 1'b0; lock = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] g; logic [3:0] ix; logic v; logic l;
        do_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            get_out(i, g, ix, v, l);
            checks++;
            if (g !== 4'b0000 || ix !== 4'b0000 || v !== 1'b0 || l !== 1'b0) begin
                errors++;
                $display("FAIL reset inst%0d: gnt=%b idx=%0d valid=%b locked=%b expected all zero",
                         i, g, ix, v, l);
            end
        end
    endtask

    task automatic test_rr_rotation();
        int seq4[5] = '{0, 1, 2, 3, 0};
        int seq3[5] = '{0, 1, 2, 0, 1};
        do_reset();
        req = 4'b1111; update = 1'b1; lock = 1'b0;
        for (int b = 0; b < 5; b++) begin
            #1;
            checks++;
            if (idx0 !== 2'(seq4[b]) || gnt0 !== (4'b0001 << seq4[b])) begin
                errors++;
                $display("FAIL rr4_rotate beat %0d: idx=%0d gnt=%b expected idx %0d", b, idx0, gnt0, seq4[b]);
            end
            checks++;
            if (idx2 !== 2'(seq3[b])) begin
                errors++;
                $display("FAIL rr3_wrap beat %0d: idx=%0d expected %0d", b, idx2, seq3[b]);
            end
            step();
        end
    endtask

    task automatic test_rr_wrap_search();
        do_reset();
        req = 4'b0010; update = 1'b1; lock = 1'b0;
        step();
        req = 4'b0011;
        #1;
        checks++;
        if (idx0 !== 2'd0 || gnt0 !== 4'b0001) begin
            errors++;
            $display("FAIL rr_wrap_search: idx=%0d gnt=%b expected idx 0 gnt 0001", idx0, gnt0);
        end
        step();
        #1;
        checks++;
        if (idx0 !== 2'd1) begin
            errors++;
            $display("FAIL rr_ptr_after_wrap: idx=%0d expected 1", idx0);
        end
    endtask

    task automatic test_fpa_starve();
        do_reset();
        req = 4'b1010; update = 1'b1; lock = 1'b0;
        for (int b = 0; b < 3; b++) begin
            #1;
            checks++;
            if (idx1 !== 2'd1 || gnt1 !== 4'b0010) begin
                errors++;
                $display("FAIL fpa_priority beat %0d: idx=%0d gnt=%b expected idx 1", b, idx1, gnt1);
            end
            step();
        end
    endtask

    task automatic test_lock();
        do_reset();
        req = 4'b0001; update = 1'b1; lock = 1'b0;
        step();
        req = 4'b1111; lock = 1'b1;
        for (int b = 0; b < 3; b++) begin
            #1;
            checks++;
            if (gnt0 !== 4'b0010 || lkd0 !== (b != 0)) begin
                errors++;
                $display("FAIL lock_hold beat %0d: gnt=%b locked=%b expected gnt 0010", b, gnt0, lkd0);
            end
            step();
        end
        lock = 1'b0;
        #1;
        checks++;
        if (gnt0 !== 4'b0010 || lkd0 !== 1'b1) begin
            errors++;
            $display("FAIL lock_last_beat: gnt=%b locked=%b expected 0010 locked 1", gnt0, lkd0);
        end
        step();
        update = 1'b0;
        #1;
        checks++;
        if (idx0 !== 2'd2 || lkd0 !== 1'b0) begin
            errors++;
            $display("FAIL lock_release: idx=%0d locked=%b expected idx 2 locked 0", idx0, lkd0);
        end
    endtask

    task automatic test_lock_stall();
        do_reset();
        req = 4'b0010; update = 1'b1; lock = 1'b1;
        step();
        req = 4'b1101; lock = 1'b0;
        for (int b = 0; b < 2; b++) begin
            #1;
            checks++;
            if (val0 !== 1'b0 || gnt0 !== 4'b0000 || lkd0 !== 1'b1 || idx0 !== 2'd0) begin
                errors++;
                $display("FAIL lock_stall cycle %0d: valid=%b gnt=%b locked=%b idx=%0d expected 0/0000/1/0",
                         b, val0, gnt0, lkd0, idx0);
            end
            step();
        end
        req = 4'b1111; update = 1'b0;
        #1;
        checks++;
        if (idx0 !== 2'd1 || gnt0 !== 4'b0010 || lkd0 !== 1'b1) begin
            errors++;
            $display("FAIL lock_resume: idx=%0d gnt=%b locked=%b expected idx 1 locked 1", idx0, gnt0, lkd0);
        end
        update = 1'b1;
        step();
    endtask

    task automatic test_rst_mid_packet();
        do_reset();
        req = 4'b0100; update = 1'b1; lock = 1'b0;
        step();
        req = 4'b1111; lock = 1'b1;
        step();
        update = 1'b0;
        #1;
        checks++;
        if (gnt0 !== 4'b1000 || lkd0 !== 1'b1) begin
            errors++;
            $display("FAIL lock_idx3: gnt=%b locked=%b expected 1000 locked 1", gnt0, lkd0);
        end
        rst = 1'b1; update = 1'b1; lock = 1'b1;
        step();
        rst = 1'b0; update = 1'b0; lock = 1'b0;
        #1;
        checks++;
        if (lkd0 !== 1'b0 || idx0 !== 2'd0 || gnt0 !== 4'b0001) begin
            errors++;
            $display("FAIL rst_mid_packet: locked=%b idx=%0d gnt=%b expected 0/0/0001", lkd0, idx0, gnt0);
        end
    endtask

    task automatic test_none();
        do_reset();
        req = 4'b0001;
        #1;
        checks++;
        if (gnt3 !== 1'b1 || idx3 !== 1'b0 || val3 !== 1'b1) begin
            errors++;
            $display("FAIL none_grant: gnt=%b idx=%0d valid=%b expected 1/0/1", gnt3, idx3, val3);
        end
        req = 4'b1110;
        #1;
        checks++;
        if (gnt3 !== 1'b0 || val3 !== 1'b0) begin
            errors++;
            $display("FAIL none_idle: gnt=%b valid=%b expected 0/0", gnt3, val3);
        end
    endtask

    task automatic test_random();
        logic [3:0] g; logic [3:0] ix; logic v; logic l;
        logic [3:0] eg; logic [3:0] eix; int w;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req    = 4'($urandom_range(0, 15));
            update = ($urandom_range(0, 2) != 0);
            lock   = $urandom_range(0, 1) == 1;
            rst    = ($urandom_range(0, 39) == 0);
            #1;
            for (int i = 0; i < 4; i++) begin
                w   = exp_winner(i, req);
                eg  = (w >= 0) ? (4'b0001 << w) : 4'b0000;
                eix = (w >= 0) ? 4'(w) : 4'b0000;
                get_out(i, g, ix, v, l);
                checks++;
                if (g !== eg || ix !== eix || v !== (w >= 0) || l !== m_lock[i]) begin
                    errors++;
                    $display("FAIL random c%0d inst%0d req=%b: gnt=%b idx=%0d valid=%b locked=%b expected %b/%0d/%b/%b",
                             c, i, req, g, ix, v, l, eg, eix, (w >= 0), m_lock[i]);
                end
            end
            step();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; update = 1'b0; lock = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_ptr[i] = 0; m_lidx[i] = 0; m_lock[i] = 1'b0;
        end
        test_reset();
        test_rr_rotation();
        test_rr_wrap_search();
        test_fpa_starve();
        test_lock();
        test_lock_stall();
        test_rst_mid_packet();
        test_none();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
